watch_set_ctrl: RTL and testbench

//  Time-set controller for the hh:mm watch datapath. Turns the two raw push buttons
//  (bt0 = mode, bt1 = adjust) into debounced press events, then steps a set-mode FSM.

---
 rtl/watch_set_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_watch_set_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/watch_set_ctrl.sv
// rtl/watch_set_ctrl.sv - time-set controller for the hh:mm watch datapath
//
// Purpose: debounces the mode (bt0) and adjust (bt1) buttons, steps the
//   RUN -> SET_HH -> SET_MM -> RUN set-mode FSM and drives one-cycle
//   increment/clear strobes, run-enable and 2 Hz digit-blink enables.
//   All logic runs on the 32.768 kHz crystal clock.
// Optional feature: define WATCH_SET_AUTO_REPEAT_EN to enable adjust
//   auto-repeat (long press, then periodic inc strobes until release).
// Ports:
//   clk_crystal_i  in   crystal clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   bt0_i / bt1_i  in   raw mode / adjust buttons, active-high, asynchronous
//   mode_o         out  2'b00 RUN, 2'b01 SET_HH, 2'b10 SET_MM
//   run_en_o       out  1 while in RUN
//   inc_hour_o     out  one-cycle hours +1 strobe
//   inc_min_o      out  one-cycle minutes +1 strobe
//   clr_sec_o      out  one-cycle clear-seconds strobe on leaving SET_MM
//   blink_hh_o     out  hour digits visible when 1
//   blink_mm_o     out  minute digits visible when 1
module watch_set_ctrl #(
  parameter int CLK_HZ            = 32768,
  parameter int DEBOUNCE_CYCLES   = 655,
  parameter int TIMEOUT_CYCLES    = 983040,
  parameter int LONG_PRESS_CYCLES = 32768,
  parameter int REPEAT_CYCLES     = 8192
) (
  input  logic       clk_crystal_i,
  input  logic       rst_i,
  input  logic       bt0_i,
  input  logic       bt1_i,
  output logic [1:0] mode_o,
  output logic       run_en_o,
  output logic       inc_hour_o,
  output logic       inc_min_o,
  output logic       clr_sec_o,
  output logic       blink_hh_o,
  output logic       blink_mm_o
);

  localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BLINK_HALF = CLK_HZ / 4;
  localparam int BL_W       = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    S_RUN    = 2'b00,
    S_SET_HH = 2'b01,
    S_SET_MM = 2'b10
  } state_t;

  // Bit 0 = bt0 (mode), bit 1 = bt1 (adjust)
  logic [1:0]           sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [1:0][DB_W-1:0] db_cnt_q;
  logic [1:0]           press;
  logic                 p0, p1, rpt_fire, adj;

  state_t               state_q, state_d;
  logic [TO_W-1:0]      timer_q, timer_d;
  logic                 inc_hour_q, inc_hour_d;
  logic                 inc_min_q, inc_min_d;
  logic                 clr_sec_q, clr_sec_d;
  logic [BL_W-1:0]      bl_cnt_q, bl_cnt_d;
  logic                 phase_q, phase_d;

  // Synchroniser + debouncer: the counter only runs while the synchronised
  // level disagrees with the accepted level, so any glitch shorter than
  // DEBOUNCE_CYCLES resets it before the accepted level can flip.
  always_ff @(posedge clk_crystal_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= {bt1_i, bt0_i};
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] != deb_q[i]) begin
          if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            deb_q[i]    <= ~deb_q[i];
            db_cnt_q[i] <= '0;
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
          end
        end else begin
          db_cnt_q[i] <= '0;
        end
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;
  assign p0    = press[0];
  // A mode press in the same cycle swallows the adjust press
  assign p1    = press[1] & ~press[0];
  assign adj   = p1 | rpt_fire;

`ifdef WATCH_SET_AUTO_REPEAT_EN
  localparam int RP_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  logic            rpt_armed_q, rpt_armed_d;
  logic            rpt_long_q, rpt_long_d;
  logic [RP_W-1:0] rpt_cnt_q, rpt_cnt_d;

  // Armed on an adjust press; first repeat after the long-press hold, then
  // one per repeat period. Dropped on release, mode press or leaving SET.
  always_comb begin
    rpt_armed_d = rpt_armed_q;
    rpt_long_d  = rpt_long_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_fire    = 1'b0;
    if ((state_q == S_RUN) || press[0] || !deb_q[1]) begin
      rpt_armed_d = 1'b0;
      rpt_long_d  = 1'b0;
      rpt_cnt_d   = '0;
    end else if (p1) begin
      rpt_armed_d = 1'b1;
      rpt_long_d  = 1'b0;
      rpt_cnt_d   = '0;
    end else if (rpt_armed_q) begin
      if (rpt_cnt_q == (rpt_long_q ? RP_W'(REPEAT_CYCLES - 1) : RP_W'(LONG_PRESS_CYCLES - 1))) begin
        rpt_fire   = 1'b1;
        rpt_cnt_d  = '0;
        rpt_long_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_crystal_i or posedge rst_i) begin
    if (rst_i) begin
      rpt_armed_q <= 1'b0;
      rpt_long_q  <= 1'b0;
      rpt_cnt_q   <= '0;
    end else begin
      rpt_armed_q <= rpt_armed_d;
      rpt_long_q  <= rpt_long_d;
      rpt_cnt_q   <= rpt_cnt_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Set-mode FSM, idle timeout and registered strobes
  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    inc_hour_d = 1'b0;
    inc_min_d  = 1'b0;
    clr_sec_d  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (p0) state_d = S_SET_HH;
      end
      S_SET_HH: begin
        if (p0)       state_d    = S_SET_MM;
        else if (adj) inc_hour_d = 1'b1;
      end
      S_SET_MM: begin
        if (p0) begin
          state_d   = S_RUN;
          clr_sec_d = 1'b1;
        end else if (adj) begin
          inc_min_d = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
    if ((state_q == S_SET_HH || state_q == S_SET_MM) && !(p0 || adj)) begin
      if (timer_q == TO_W'(TIMEOUT_CYCLES - 1)) state_d = S_RUN;
      else                                        timer_d = timer_q + 1'b1;
    end
  end

  // Blink prescaler restarts visible on every state change
  always_comb begin
    bl_cnt_d = bl_cnt_q + 1'b1;
    phase_d  = phase_q;
    if (state_d != state_q) begin
      bl_cnt_d = '0;
      phase_d  = 1'b1;
    end else if (bl_cnt_q == BL_W'(BLINK_HALF - 1)) begin
      bl_cnt_d = '0;
      phase_d  = ~phase_q;
    end
  end

  always_ff @(posedge clk_crystal_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_RUN;
      timer_q    <= '0;
      inc_hour_q <= 1'b0;
      inc_min_q  <= 1'b0;
      clr_sec_q  <= 1'b0;
      bl_cnt_q   <= '0;
      phase_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      inc_hour_q <= inc_hour_d;
      inc_min_q  <= inc_min_d;
      clr_sec_q  <= clr_sec_d;
      bl_cnt_q   <= bl_cnt_d;
      phase_q    <= phase_d;
    end
  end

  assign mode_o     = state_q;
  assign run_en_o   = (state_q == S_RUN);
  assign inc_hour_o = inc_hour_q;
  assign inc_min_o  = inc_min_q;
  assign clr_sec_o  = clr_sec_q;
  assign blink_hh_o = (state_q != S_SET_HH) | phase_q;
  assign blink_mm_o = (state_q != S_SET_MM) | phase_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// tb/tb_watch_set_ctrl.sv - self-checking bench for watch_set_ctrl
module tb_watch_set_ctrl;

  logic       clk, rst, bt0, bt1;
  logic [1:0] mode;
  logic       run_en, inc_hour, inc_min, clr_sec, blink_hh, blink_mm;

  int errors = 0;
  int checks = 0;
  int n_hour = 0, n_min = 0, n_clr = 0, viol = 0;
  logic prev_h = 0, prev_m = 0, prev_c = 0;

  watch_set_ctrl #(
    .CLK_HZ(32), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100),
    .LONG_PRESS_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .clk_crystal_i(clk), .rst_i(rst), .bt0_i(bt0), .bt1_i(bt1),
    .mode_o(mode), .run_en_o(run_en), .inc_hour_o(inc_hour), .inc_min_o(inc_min),
    .clr_sec_o(clr_sec), .blink_hh_o(blink_hh), .blink_mm_o(blink_mm)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Strobe scoreboard: counts pulses, flags overlap or width > 1 cycle
  always @(negedge clk) begin
    if (!rst) begin
      n_hour += int'(inc_hour);
      n_min  += int'(inc_min);
      n_clr  += int'(clr_sec);
      if (int'(inc_hour) + int'(inc_min) + int'(clr_sec) > 1) viol++;
      if ((prev_h && inc_hour) || (prev_m && inc_min) || (prev_c && clr_sec)) viol++;
    end
    prev_h = inc_hour;
    prev_m = inc_min;
    prev_c = clr_sec;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic b0, input logic b1, input int hold);
    bt0 = b0;
    bt1 = b1;
    cyc(hold);
    bt0 = 0;
    bt1 = 0;
    cyc(14);
  endtask

  typedef struct {
    logic b0;
    logic b1;
    int   exp_mode;
    int   d_hour;
    int   d_min;
    int   d_clr;
  } vec_t;

  vec_t vecs[12];
  int   h0, m0, c0, bad;
  int   hits[$];
  int   exp_hits[$];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 0, 0, 0, 0};  // adjust ignored in RUN
    vecs[1]  = '{1'b1, 1'b0, 1, 0, 0, 0};  // RUN -> SET_HH
    vecs[2]  = '{1'b0, 1'b1, 1, 1, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 1, 1, 0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1, 1, 0, 0};
    vecs[5]  = '{1'b1, 1'b0, 2, 0, 0, 0};  // SET_HH -> SET_MM
    vecs[6]  = '{1'b0, 1'b1, 2, 0, 1, 0};
    vecs[7]  = '{1'b0, 1'b1, 2, 0, 1, 0};
    vecs[8]  = '{1'b1, 1'b0, 0, 0, 0, 1};  // SET_MM -> RUN with clr
    vecs[9]  = '{1'b1, 1'b0, 1, 0, 0, 0};
    vecs[10] = '{1'b1, 1'b1, 2, 0, 0, 0};  // simultaneous: mode wins
    vecs[11] = '{1'b1, 1'b0, 0, 0, 0, 1};

    rst = 1; bt0 = 0; bt1 = 0;
    cyc(3);
    chk("reset_mode", int'(mode), 0);
    chk("reset_run_en", int'(run_en), 1);
    chk("reset_strobes", int'({inc_hour, inc_min, clr_sec}), 0);
    chk("reset_blink", int'({blink_hh, blink_mm}), 3);
    rst = 0;
    cyc(3);

    // Glitch of 3 cycles is filtered
    bt0 = 1; cyc(3); bt0 = 0; cyc(12);
    chk("glitch_no_change", int'(mode), 0);

    // Clean rise: state change exactly 7 cycles later
    bt0 = 1;
    cyc(6);
    chk("latency_before", int'(mode), 0);
    cyc(1);
    chk("latency_at7_mode", int'(mode), 1);
    chk("latency_at7_run_en", int'(run_en), 0);
    cyc(5); bt0 = 0; cyc(14);
    press(1, 0, 10);
    press(1, 0, 10);
    chk("back_to_run", int'(mode), 0);

    for (int i = 0; i < 12; i++) begin
      h0 = n_hour; m0 = n_min; c0 = n_clr;
      press(vecs[i].b0, vecs[i].b1, 10);
      chk($sformatf("vec%0d_mode", i), int'(mode), vecs[i].exp_mode);
      chk($sformatf("vec%0d_run_en", i), int'(run_en), (vecs[i].exp_mode == 0) ? 1 : 0);
      chk($sformatf("vec%0d_hour", i), n_hour - h0, vecs[i].d_hour);
      chk($sformatf("vec%0d_min", i), n_min - m0, vecs[i].d_min);
      chk($sformatf("vec%0d_clr", i), n_clr - c0, vecs[i].d_clr);
    end

    // Timeout from SET_MM and blink cadence
    press(1, 0, 10);
    bt0 = 1;
    cyc(7);
    chk("enter_set_mm", int'(mode), 2);
    c0 = n_clr;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (blink_mm != (((k / 8) % 2) == 0)) bad++;
      if (blink_hh != 1'b1) bad++;
      if (k == 1) bt0 = 0;
      cyc(1);
    end
    chk("blink_mm_cadence", bad, 0);
    cyc(67);
    chk("timeout_at99", int'(mode), 2);
    cyc(1);
    chk("timeout_at100", int'(mode), 0);
    cyc(2);
    chk("timeout_no_clr", n_clr - c0, 0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if ({blink_hh, blink_mm} != 2'b11) bad++;
      cyc(1);
    end
    chk("blink_run_const", bad, 0);

    // Reset held mid-SET_HH
    press(1, 0, 10);
    chk("pre_reset_set_hh", int'(mode), 1);
    h0 = n_hour; m0 = n_min; c0 = n_clr;
    rst = 1;
    #1;
    chk("midset_reset_mode", int'(mode), 0);
    chk("midset_reset_run_en", int'(run_en), 1);
    chk("midset_reset_blink", int'({blink_hh, blink_mm}), 3);
    cyc(3);
    rst = 0;
    cyc(10);
    chk("after_reset_mode", int'(mode), 0);
    chk("after_reset_no_strobe", (n_hour - h0) + (n_min - m0) + (n_clr - c0), 0);

    // Adjust held 50 cycles in SET_HH
    press(1, 0, 10);
`ifdef WATCH_SET_AUTO_REPEAT_EN
    exp_hits = '{7, 27, 35, 43, 51};
`else
    exp_hits = '{7};
`endif
    bt1 = 1;
    for (int k = 1; k <= 70; k++) begin
      cyc(1);
      if (inc_hour) hits.push_back(k);
      if (k == 50) bt1 = 0;
    end
    chk("hold_strobe_count", hits.size(), exp_hits.size());
    for (int i = 0; i < exp_hits.size(); i++)
      chk($sformatf("hold_strobe%0d_cycle", i), (i < hits.size()) ? hits[i] : -1, exp_hits[i]);
    chk("hold_no_min", int'(mode), 1);

    chk("strobe_exclusive_single", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
